// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-chain sequencer: FSM states, select-LFSR
// polynomial and default seed.
package sc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FLUSH,
    ST_ACCUM,
    ST_DONE
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, taps at bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] SEED_DEF  = 16'hACE1;

endpackage

// File: rtl/sc_chain_sequencer_if.sv
// Host-side start/busy/done handshake of the chain sequencer.
interface sc_chain_sequencer_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] result;

  modport master (output start, len, input busy, done, result);
  modport slave  (input start, len, output busy, done, result);
endinterface

// File: rtl/sc_lfsr.sv
// Fibonacci LFSR (shift toward MSB, feedback into bit 0) with load and step
// controls; exposes the low OUT_W bits of both the current and the next value.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int           W     = 16,
  parameter int           OUT_W = W,
  parameter logic [W-1:0] TAPS  = W'(LFSR_TAPS),
  parameter logic [W-1:0] SEED  = W'(SEED_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [OUT_W-1:0] state,
  output logic [OUT_W-1:0] state_nxt
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED_EFF;
    end else if (step) begin
      lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state     = lfsr_q[OUT_W-1:0];
  assign state_nxt = lfsr_d[OUT_W-1:0];

endmodule

// File: rtl/sc_chain_sequencer.sv
// Runs one stochastic evaluation of an N-input adder chain: clear, flush the
// chain's fill latency, count ones on sum_in over len cycles, report the count.
module sc_chain_sequencer
  import sc_pkg::*;
#(
  parameter int                N      = 2,
  parameter int                LEN_W  = 16,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(SEED_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  sc_chain_sequencer_if.slave  host,
  output logic                 chain_clr,
  output logic                 src_en,
  output logic [N-2:0]         sel,
  input  logic                 sum_in
);

  localparam logic [LEN_W-1:0] FLUSH_CNT = LEN_W'(N - 2);
  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] ones_q, ones_d;
  logic [LEN_W-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             clr_q, clr_d;
  logic             src_q, src_d;
  logic             done_q, done_d;
  logic [N-2:0]     sel_q, sel_d;

  logic             lfsr_load;
  logic             lfsr_step;
  logic [N-2:0]     lfsr_cur;
  logic [N-2:0]     lfsr_nxt;

  sc_lfsr #(
    .W     (LFSR_W),
    .OUT_W (N - 1),
    .TAPS  (LFSR_W'(LFSR_TAPS)),
    .SEED  (SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load      (lfsr_load),
    .step      (lfsr_step),
    .state     (lfsr_cur),
    .state_nxt (lfsr_nxt)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    ones_d    = ones_q;
    result_d  = result_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (host.start) begin
          len_d     = host.len;
          ones_d    = '0;
          lfsr_load = 1'b1;
          state_d   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (N > 2) begin
          cnt_d   = FLUSH_CNT;
          state_d = ST_FLUSH;
        end else if (len_q != '0) begin
          cnt_d   = len_q;
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_FLUSH: begin
        lfsr_step = 1'b1;
        if (cnt_q == ONE) begin
          if (len_q != '0) begin
            cnt_d   = len_q;
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_ACCUM: begin
        lfsr_step = 1'b1;
        ones_d    = ones_q + LEN_W'(sum_in);
        if (cnt_q == ONE) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Result is loaded on entry to DONE so it is valid together with the pulse.
    if (state_d == ST_DONE) begin
      result_d = ones_d;
    end

    busy_d = (state_d != ST_IDLE);
    clr_d  = (state_d == ST_CLEAR);
    src_d  = (state_d == ST_FLUSH) || (state_d == ST_ACCUM);
    done_d = (state_d == ST_DONE);

    // sel mirrors the LFSR value of the cycle it is presented in; the first
    // enabled cycle shows the unstepped seed, later ones the stepped value.
    sel_d = sel_q;
    if (src_d) begin
      sel_d = lfsr_step ? lfsr_nxt : lfsr_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      ones_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      clr_q    <= 1'b0;
      src_q    <= 1'b0;
      done_q   <= 1'b0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      ones_q   <= ones_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      clr_q    <= clr_d;
      src_q    <= src_d;
      done_q   <= done_d;
      sel_q    <= sel_d;
    end
  end

  assign host.busy   = busy_q;
  assign host.done   = done_q;
  assign host.result = result_q;
  assign chain_clr   = clr_q;
  assign src_en      = src_q;
  assign sel         = sel_q;

endmodule
